// File: rtl/timer_pkg.sv
// timer_pkg: types and constants shared by the timer files.
//   TIMER_WIDTH   : default bit width of the period register and the count
//   timer_state_e : controller states IDLE / ARMED / RUN
package timer_pkg;

  localparam int TIMER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: WIDTH-bit up counter with a synchronous clear and an enable.
// The clear input has priority over the enable input.
//   clk_i   : clock, rising edge
//   clr_i   : synchronous clear to zero
//   en_i    : increment by one when high and clr_i is low
//   count_o : current count value
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable cycle timer with a cfg_valid/cfg_ready
// configuration handshake, one-shot or auto-reload mode, a terminal-count
// tick and a sticky interrupt flag.
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   cfg_valid_i    : configuration offered this cycle
//   cfg_ready_o    : configuration can be accepted (IDLE or ARMED)
//   cfg_period_i   : terminal period P in cycles
//   cfg_periodic_i : 1 = auto-reload, 0 = one-shot
//   start_i        : begin counting (single-cycle request)
//   stop_i         : abort counting (single-cycle request)
//   busy_o         : high while in RUN
//   count_o        : current count value
//   tick_o         : terminal-count pulse (RUN and count == P-1)
//   irq_o          : sticky interrupt flag
//   irq_clr_i      : clear irq_o
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_periodic_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             irq_o,
  input  logic             irq_clr_i
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             irq_q, irq_d;
  logic             cnt_clr, cnt_en;
  logic             cfg_hs;
  logic [WIDTH-1:0] count;

  timer_counter #(.WIDTH(WIDTH)) u_counter (
    .clk_i   (clk_i),
    .clr_i   (cnt_clr | rst_i),
    .en_i    (cnt_en),
    .count_o (count)
  );

  assign cfg_ready_o = (state_q != RUN);
  assign cfg_hs      = cfg_valid_i && cfg_ready_o;
  // Period cannot change while in RUN and RUN is only entered with a
  // nonzero period, so P-1 never underflows when the compare matters.
  assign tick_o      = (state_q == RUN) && (count == (period_q - WIDTH'(1)));
  assign busy_o      = (state_q == RUN);
  assign count_o     = count;
  assign irq_o       = irq_q;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    irq_d      = irq_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;

    // A tick sets the flag even when a clear arrives in the same cycle.
    if (tick_o) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          period_d   = cfg_period_i;
          periodic_d = cfg_periodic_i;
          state_d    = ARMED;
        end
      end
      ARMED: begin
        // A new configuration takes precedence over a coincident start.
        if (cfg_hs) begin
          period_d   = cfg_period_i;
          periodic_d = cfg_periodic_i;
        end else if (start_i && (period_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_en  = 1'b1;
        cnt_clr = stop_i || tick_o;
        if (stop_i || (tick_o && !periodic_q)) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed and randomized stimulus for timer_ctrl, checked
// every cycle against a behavioural model that tracks the number of cycles
// spent running and derives count and tick from it by modulo arithmetic.
module tb_timer_ctrl;

  localparam int W = 8;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;

  logic         clk;
  logic         rst;
  logic         cfgValid;
  logic         cfgReady;
  logic [W-1:0] cfgPeriod;
  logic         cfgPeriodic;
  logic         start;
  logic         stop;
  logic         busy;
  logic [W-1:0] count;
  logic         tick;
  logic         irq;
  logic         irqClr;

  int checks = 0;
  int errors = 0;

  int mState;
  int mPeriod;
  int mPeriodic;
  int mIrq;
  int mRunCycles;
  bit modelValid = 0;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_valid_i    (cfgValid),
    .cfg_ready_o    (cfgReady),
    .cfg_period_i   (cfgPeriod),
    .cfg_periodic_i (cfgPeriodic),
    .start_i        (start),
    .stop_i         (stop),
    .busy_o         (busy),
    .count_o        (count),
    .tick_o         (tick),
    .irq_o          (irq),
    .irq_clr_i      (irqClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected count: cycles elapsed in RUN, folded into the period.
  function automatic int expCount();
    if (mState != M_RUN) return 0;
    return mRunCycles % mPeriod;
  endfunction

  function automatic int expTick();
    if (mState != M_RUN) return 0;
    return ((mRunCycles % mPeriod) == mPeriod - 1) ? 1 : 0;
  endfunction

  function automatic void checkVal(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  task automatic checkOutput();
    if (modelValid) begin
      checkVal("cfg_ready", int'(cfgReady), (mState != M_RUN) ? 1 : 0);
      checkVal("busy", int'(busy), (mState == M_RUN) ? 1 : 0);
      checkVal("count", int'(count), expCount());
      checkVal("tick", int'(tick), expTick());
      checkVal("irq", int'(irq), mIrq);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic modelUpdate();
    int t;
    t = expTick();
    if (rst) begin
      mState     = M_IDLE;
      mPeriod    = 0;
      mPeriodic  = 0;
      mIrq       = 0;
      mRunCycles = 0;
      modelValid = 1;
    end else if (modelValid) begin
      if (t == 1) mIrq = 1;
      else if (irqClr) mIrq = 0;
      if (mState != M_RUN) begin
        if (cfgValid) begin
          mPeriod   = int'(cfgPeriod);
          mPeriodic = int'(cfgPeriodic);
          mState    = M_ARMED;
        end else if (mState == M_ARMED && start && mPeriod != 0) begin
          mState     = M_RUN;
          mRunCycles = 0;
        end
      end else begin
        if (stop || (t == 1 && mPeriodic == 0)) begin
          mState     = M_ARMED;
          mRunCycles = 0;
        end else begin
          mRunCycles++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, then clock the model.
  task automatic applyStimulus(input logic r, input logic cv, input logic [W-1:0] per,
                               input logic pm, input logic st, input logic sp,
                               input logic ic);
    rst         = r;
    cfgValid    = cv;
    cfgPeriod   = per;
    cfgPeriodic = pm;
    start       = st;
    stop        = sp;
    irqClr      = ic;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic doCfg(input logic [W-1:0] per, input logic pm);
    applyStimulus(0, 1, per, pm, 0, 0, 0);
  endtask

  task automatic doStart();
    applyStimulus(0, 0, '0, 0, 1, 0, 0);
  endtask

  task automatic doStop();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
  endtask

  task automatic doIrqClr();
    applyStimulus(0, 0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; cfgValid = 1'b0; cfgPeriod = '0; cfgPeriodic = 1'b0;
    start = 1'b0; stop = 1'b0; irqClr = 1'b0;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, '0, 0, 0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0, 0, 0);
    checkVal("rst_cfg_ready", int'(cfgReady), 1);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_count", int'(count), 0);
    checkVal("rst_irq", int'(irq), 0);
    checkVal("rst_tick", int'(tick), 0);
    doStart();
    checkVal("start_noconfig_busy", int'(busy), 0);

    $display("[TB] periodic P=4");
    doCfg(8'd4, 1);
    checkVal("cfg_busy", int'(busy), 0);
    doStart();
    checkVal("p4_busy", int'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      checkVal("p4_count", int'(count), i % 4);
      checkVal("p4_tick", int'(tick), (i % 4 == 3) ? 1 : 0);
      checkVal("p4_irq", int'(irq), (i >= 4) ? 1 : 0);
      idle(1);
    end
    doStop();
    checkVal("p4_stop_busy", int'(busy), 0);
    checkVal("p4_stop_count", int'(count), 0);
    doIrqClr();
    checkVal("irq_cleared", int'(irq), 0);

    $display("[TB] one-shot P=3");
    doCfg(8'd3, 0);
    doStart();
    for (int i = 0; i < 3; i++) begin
      checkVal("os_count", int'(count), i);
      checkVal("os_tick", int'(tick), (i == 2) ? 1 : 0);
      idle(1);
    end
    checkVal("os_done_busy", int'(busy), 0);
    checkVal("os_done_count", int'(count), 0);
    checkVal("os_irq", int'(irq), 1);
    doStart();
    checkVal("os_rerun_busy", int'(busy), 1);
    idle(3);
    checkVal("os_rerun_done", int'(busy), 0);

    $display("[TB] stop at count 2, P=5");
    doCfg(8'd5, 1);
    doStart();
    idle(2);
    checkVal("stop2_count", int'(count), 2);
    checkVal("stop2_tick", int'(tick), 0);
    doStop();
    checkVal("stop2_busy", int'(busy), 0);
    checkVal("stop2_count0", int'(count), 0);

    $display("[TB] stop coincident with tick");
    doIrqClr();
    doStart();
    idle(4);
    checkVal("stoptick_tick", int'(tick), 1);
    doStop();
    checkVal("stoptick_busy", int'(busy), 0);
    checkVal("stoptick_irq", int'(irq), 1);

    $display("[TB] P=0 start ignored");
    doCfg(8'd0, 1);
    doStart();
    checkVal("p0_busy", int'(busy), 0);

    $display("[TB] config during RUN ignored");
    doCfg(8'd6, 1);
    doStart();
    checkVal("run_cfg_ready", int'(cfgReady), 0);
    doCfg(8'd2, 0);
    idle(4);
    checkVal("run_cfg_count", int'(count), 5);
    checkVal("run_cfg_tick", int'(tick), 1);
    idle(1);
    checkVal("run_cfg_wrap", int'(busy), 1);

    $display("[TB] irq_clr coincident with tick");
    doStop();
    doIrqClr();
    doCfg(8'd2, 1);
    doStart();
    idle(1);
    checkVal("clrtick_tick", int'(tick), 1);
    doIrqClr();
    checkVal("clrtick_irq", int'(irq), 1);

    $display("[TB] reset mid-RUN");
    doStop();
    doCfg(8'd8, 1);
    doStart();
    idle(5);
    checkVal("midrst_count", int'(count), 5);
    applyStimulus(1, 1, 8'd3, 0, 1, 1, 1);
    checkVal("midrst_busy", int'(busy), 0);
    checkVal("midrst_count0", int'(count), 0);
    checkVal("midrst_irq", int'(irq), 0);
    checkVal("midrst_ready", int'(cfgReady), 1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      logic r, cv, pm, st, sp, ic;
      logic [W-1:0] per;
      r   = ($urandom_range(0, 199) == 0);
      cv  = ($urandom_range(0, 9) == 0);
      per = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 7));
      pm  = W'($urandom_range(0, 1)) != 0;
      st  = ($urandom_range(0, 4) == 0);
      sp  = ($urandom_range(0, 24) == 0);
      ic  = ($urandom_range(0, 9) == 0);
      applyStimulus(r, cv, per, pm, st, sp, ic);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bit width of period register and count output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cfg_valid  input  1  configuration offered this cycle.
REQ-005 cfg_ready  output  1  configuration can be accepted this cycle.
REQ-006 cfg_period  input  WIDTH  terminal period P, in cycles.
REQ-007 cfg_periodic  input  1  1 = auto-reload, 0 = one-shot.
REQ-008 start  input  1  begin counting, single-cycle request.
REQ-009 stop  input  1  abort counting, single-cycle request.
REQ-010 busy  output  1  high while in RUN.
REQ-011 count  output  WIDTH  current count value.
REQ-012 tick  output  1  terminal-count pulse.
REQ-013 irq  output  1  sticky interrupt flag.
REQ-014 irq_clr  input  1  clear irq.

Function
REQ-015 The block SHALL implement three states: IDLE, ARMED and RUN.
REQ-016 cfg_ready SHALL be 1 in IDLE and ARMED, and 0 in RUN.
REQ-017 A handshake SHALL occur when cfg_valid && cfg_ready; period and mode SHALL then be latched and the state SHALL become ARMED at the next edge.
REQ-018 A configuration presented in ARMED SHALL overwrite the stored period and mode; cfg_valid in RUN SHALL be ignored.
REQ-019 In ARMED, start with stored P != 0 SHALL move to RUN with count = 0 after the edge; start with P == 0 SHALL be ignored.
REQ-020 start in IDLE or in RUN SHALL be ignored; start and cfg handshake in the same ARMED cycle: the new config SHALL be latched and start SHALL be ignored.
REQ-021 In RUN, count SHALL increment by 1 per cycle, modulo P.
REQ-022 tick SHALL be combinational and equal (state == RUN && count == P-1); it SHALL therefore be high for exactly one cycle per period.
REQ-023 On the edge ending a tick cycle, count SHALL wrap to 0.
  - Periodic mode: state SHALL remain RUN.
  - One-shot mode: state SHALL become ARMED.
REQ-024 P == 1 in periodic mode SHALL assert tick on every RUN cycle, with count held at 0.
REQ-025 stop in RUN SHALL move to ARMED and clear count to 0 at the next edge; stop in IDLE or ARMED SHALL be ignored.
REQ-026 stop coincident with tick: tick SHALL still assert, irq SHALL still set, and the next state SHALL be ARMED.
REQ-027 count SHALL be 0 in IDLE and ARMED.
REQ-028 irq SHALL set on the edge after any tick cycle and clear on the edge after an irq_clr cycle; if both occur in the same cycle, set SHALL win.
REQ-029 busy SHALL equal (state == RUN).
REQ-030 Count arithmetic SHALL be WIDTH bits unsigned; max period = 2^WIDTH - 1.

Reset
REQ-031 While rst is high at a clock edge, the following SHALL hold after that edge: state IDLE, count 0, stored period 0, stored mode 0, irq 0.
REQ-032 Resulting outputs after reset: cfg_ready = 1, busy = 0, tick = 0.
REQ-033 Reset asserted mid-RUN SHALL override all other inputs in that cycle, including cfg, start, stop and irq_clr.

Structure
REQ-034 Package timer_pkg SHALL hold the state enum (IDLE/ARMED/RUN) and the WIDTH default constant.
REQ-035 Counting SHALL be done by one sub-module, timer_counter: a WIDTH-bit up counter with synchronous clear and enable.
REQ-036 timer_ctrl SHALL hold the FSM, the config registers, the terminal compare and the irq flag.

Verification
REQ-037 Reset then idle: rst high for 2 cycles -> cfg_ready = 1, busy = 0, count = 0, irq = 0; start with no config -> no change.
REQ-038 Periodic P = 4: config, then start -> count sequence 0,1,2,3,0,1,...; tick high whenever count = 3 (every 4 cycles); irq high from the cycle after the first tick.
REQ-039 One-shot P = 3: start -> count 0,1,2; tick once at count = 2; then ARMED, busy = 0, count = 0; a second start reruns the sequence.
REQ-040 Stop and conflicts:
  - stop at count = 2 with P = 5 -> ARMED and count = 0 next cycle, no tick.
  - stop coincident with tick -> tick seen, irq set, state ARMED.
REQ-041 Edge cases:
  - P = 0 config then start -> stays ARMED.
  - cfg_valid during RUN -> cfg_ready = 0 and stored period unchanged.
  - irq_clr coincident with tick -> irq stays 1.
REQ-042 Reset mid-RUN with P = 8 at count = 5 -> IDLE, count 0, irq 0 next cycle.
